// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath types: ALU operation encoding driven by the control FSM.
package riscv_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_ops_t;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional feature macro PERF_CNT_EN adds the retired-instruction counter output instret.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output logic [1:0]           imm_src,
    output riscv_pkg::alu_ops_t  alu_ctrl,
    output logic                 trap,
    output logic [1:0]           trap_cause
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]          instret
`endif
);

    localparam logic [3:0] StFetch    = 4'd0;
    localparam logic [3:0] StDecode   = 4'd1;
    localparam logic [3:0] StMemAdr   = 4'd2;
    localparam logic [3:0] StMemRead  = 4'd3;
    localparam logic [3:0] StMemWb    = 4'd4;
    localparam logic [3:0] StMemWrite = 4'd5;
    localparam logic [3:0] StExecR    = 4'd6;
    localparam logic [3:0] StExecI    = 4'd7;
    localparam logic [3:0] StAluWb    = 4'd8;
    localparam logic [3:0] StBranch   = 4'd9;
    localparam logic [3:0] StJal1     = 4'd10;
    localparam logic [3:0] StJal2     = 4'd11;
    localparam logic [3:0] StTrap     = 4'd12;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [1:0] CauseIllegal = 2'b01;
    localparam logic [1:0] CauseTimeout = 2'b10;

    // The wait counter only needs to reach TIMEOUT_CYCLES-1; the next stalled cycle traps.
    localparam int unsigned CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic WdEn = (TIMEOUT_CYCLES != 0);

    logic [3:0]          r_state;
    logic [3:0]          w_state_d;
    logic [1:0]          r_trap_cause;
    logic [1:0]          w_cause_d;
    logic [CntW-1:0]     r_wait_cnt;
    logic [CntW-1:0]     w_wait_cnt_d;
    logic                w_illegal;
    logic                w_mem_state;
    logic                w_waiting;
    logic                w_timeout;
    logic                w_f3_ok;
    riscv_pkg::alu_ops_t w_f3_op;

    // funct3 map shared by R-type and I-type ALU instructions.
    always_comb begin
        w_f3_ok = 1'b1;
        w_f3_op = riscv_pkg::ALU_ADD;
        case (funct3)
            3'b000:  w_f3_op = riscv_pkg::ALU_ADD;
            3'b100:  w_f3_op = riscv_pkg::ALU_XOR;
            3'b110:  w_f3_op = riscv_pkg::ALU_OR;
            3'b111:  w_f3_op = riscv_pkg::ALU_AND;
            default: w_f3_ok = 1'b0;
        endcase
    end

    assign w_mem_state  = (r_state == StFetch) || (r_state == StMemRead) ||
                          (r_state == StMemWrite);
    assign w_waiting    = w_mem_state && !mem_ready;
    assign w_timeout    = WdEn && w_waiting && (r_wait_cnt == CntLast);
    assign w_wait_cnt_d = (WdEn && w_waiting && !w_timeout) ? r_wait_cnt + 1'b1 : '0;

    always_comb begin
        w_state_d = r_state;
        w_illegal = 1'b0;
        case (r_state)
            StFetch: begin
                if (mem_ready) w_state_d = StDecode;
            end
            StDecode: begin
                case (opcode)
                    OpLoad, OpStore: begin
                        if (funct3 == 3'b010) w_state_d = StMemAdr;
                        else w_illegal = 1'b1;
                    end
                    OpR:   w_state_d = StExecR;
                    OpI:   w_state_d = StExecI;
                    OpBranch: begin
                        if (funct3 == 3'b000 || funct3 == 3'b001) w_state_d = StBranch;
                        else w_illegal = 1'b1;
                    end
                    OpJal:   w_state_d = StJal1;
                    default: w_illegal = 1'b1;
                endcase
            end
            StMemAdr:   w_state_d = (opcode == OpStore) ? StMemWrite : StMemRead;
            StMemRead: begin
                if (mem_ready) w_state_d = StMemWb;
            end
            StMemWrite: begin
                if (mem_ready) w_state_d = StFetch;
            end
            StExecR, StExecI: begin
                if (w_f3_ok) w_state_d = StAluWb;
                else w_illegal = 1'b1;
            end
            StMemWb, StAluWb, StBranch, StJal2: w_state_d = StFetch;
            StJal1:     w_state_d = StJal2;
            StTrap:     w_state_d = StTrap;
            default:    w_state_d = StFetch;
        endcase
        if (w_illegal || w_timeout) w_state_d = StTrap;
    end

    always_comb begin
        w_cause_d = r_trap_cause;
        if (w_timeout) w_cause_d = CauseTimeout;
        else if (w_illegal) w_cause_d = CauseIllegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StFetch;
            r_trap_cause <= 2'b00;
            r_wait_cnt   <= '0;
        end else begin
            r_state      <= w_state_d;
            r_trap_cause <= w_cause_d;
            r_wait_cnt   <= w_wait_cnt_d;
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        imm_src    = 2'b00;
        alu_ctrl   = riscv_pkg::ALU_ADD;
        case (r_state)
            StFetch: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b10;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            // ALUOut captures old_pc + B-immediate so BRANCH can use it as the target.
            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (opcode == OpStore) ? 2'b01 : 2'b00;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            StMemWb: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            StExecR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_ctrl  = (funct3 == 3'b000 && funct7_5) ? riscv_pkg::ALU_SUB : w_f3_op;
            end
            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = w_f3_op;
            end
            StAluWb: begin
                reg_write = 1'b1;
            end
            StBranch: begin
                alu_src_a = 2'b10;
                alu_ctrl  = riscv_pkg::ALU_SUB;
                pc_src    = 1'b1;
                pc_write  = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
            end
            StJal1: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_write  = 1'b1;
            end
            StJal2: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b11;
                pc_write  = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign trap       = (r_state == StTrap);
    assign trap_cause = r_trap_cause;

`ifdef PERF_CNT_EN
    logic [31:0] r_instret;
    logic        w_retire;

    assign w_retire = (w_state_d == StFetch) &&
                      ((r_state == StMemWb) || (r_state == StMemWrite) ||
                       (r_state == StAluWb) || (r_state == StBranch) || (r_state == StJal2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= 32'd0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl (watchdog shortened to 4 cycles).
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] A_ADD = riscv_pkg::ALU_ADD;
    localparam logic [2:0] A_SUB = riscv_pkg::ALU_SUB;
    localparam logic [2:0] A_AND = riscv_pkg::ALU_AND;
    localparam logic [2:0] A_OR  = riscv_pkg::ALU_OR;
    localparam logic [2:0] A_XOR = riscv_pkg::ALU_XOR;

    logic clk = 1'b0;
    logic rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic funct7_5, zero, mem_ready;
    logic mem_req, mem_write, adr_src, ir_write, pc_write, pc_src, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, trap_cause;
    riscv_pkg::alu_ops_t alu_ctrl;
    logic trap;
`ifdef PERF_CNT_EN
    logic [31:0] instret;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .imm_src    (imm_src),
        .alu_ctrl   (alu_ctrl),
        .trap       (trap),
        .trap_cause (trap_cause)
`ifdef PERF_CNT_EN
        ,
        .instret    (instret)
`endif
    );

    typedef struct {
        logic [63:0] name;
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        rdy;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Packed order: mem_req mem_write adr_src ir_write pc_write pc_src reg_write
    //               alu_src_a alu_src_b result_src imm_src alu_ctrl trap trap_cause
    function automatic logic [20:0] ex(input logic mr, input logic mw, input logic ad,
                                       input logic iw, input logic pw, input logic ps,
                                       input logic rw, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] res, input logic [1:0] imm,
                                       input logic [2:0] alu, input logic tr,
                                       input logic [1:0] c);
        return {mr, mw, ad, iw, pw, ps, rw, a, b, res, imm, alu, tr, c};
    endfunction

    function automatic logic [20:0] e_fetch(input logic rdy);
        return ex(1, 0, 0, rdy, rdy, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, A_ADD, 0, 2'b00);
    endfunction
    function automatic logic [20:0] e_dec();
        return ex(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b10, A_ADD, 0, 2'b00);
    endfunction
    function automatic logic [20:0] e_exr(input logic [2:0] alu);
        return ex(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, alu, 0, 2'b00);
    endfunction
    function automatic logic [20:0] e_exi(input logic [2:0] alu);
        return ex(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, alu, 0, 2'b00);
    endfunction
    function automatic logic [20:0] e_aluwb();
        return ex(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, A_ADD, 0, 2'b00);
    endfunction
    function automatic logic [20:0] e_madr(input logic [1:0] imm);
        return ex(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, imm, A_ADD, 0, 2'b00);
    endfunction
    function automatic logic [20:0] e_mrd();
        return ex(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, A_ADD, 0, 2'b00);
    endfunction
    function automatic logic [20:0] e_mwb();
        return ex(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, A_ADD, 0, 2'b00);
    endfunction
    function automatic logic [20:0] e_mwr();
        return ex(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, A_ADD, 0, 2'b00);
    endfunction
    function automatic logic [20:0] e_br(input logic pw);
        return ex(0, 0, 0, 0, pw, 1, 0, 2'b10, 2'b00, 2'b00, 2'b00, A_SUB, 0, 2'b00);
    endfunction
    function automatic logic [20:0] e_jal1();
        return ex(0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b10, 2'b10, 2'b00, A_ADD, 0, 2'b00);
    endfunction
    function automatic logic [20:0] e_jal2();
        return ex(0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b01, 2'b00, 2'b11, A_ADD, 0, 2'b00);
    endfunction
    function automatic logic [20:0] e_trap(input logic [1:0] c);
        return ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, A_ADD, 1, c);
    endfunction

    task automatic v(input logic [63:0] name, input logic rst, input logic [6:0] op,
                     input logic [2:0] f3, input logic f7, input logic z, input logic rdy,
                     input logic [20:0] exp);
        vec_t t;
        t.name = name; t.rst = rst; t.op = op; t.f3 = f3; t.f7 = f7;
        t.z = z; t.rdy = rdy; t.exp = exp;
        vecs.push_back(t);
    endtask

    // One clock cycle: inputs change 1ns after the rising edge.
    task automatic step(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input logic z, input logic rdy);
        @(posedge clk);
        #1;
        rst_n = ~rst; opcode = op; funct3 = f3; funct7_5 = f7; zero = z; mem_ready = rdy;
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t t);
        logic [20:0] act;
        step(t.rst, t.op, t.f3, t.f7, t.z, t.rdy);
        act = {mem_req, mem_write, adr_src, ir_write, pc_write, pc_src, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, 3'(alu_ctrl), trap, trap_cause};
        n_checks++;
        if (act !== t.exp) begin
            n_fail++;
            $display("FAIL %0s (vec %0d): got %h, expected %h", t.name, idx, act, t.exp);
        end
    endtask

    task automatic check32(input logic [63:0] name, input logic [31:0] act,
                           input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %0s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;

        v("reset",  1, 7'd0,  3'd0, 0, 0, 0, e_fetch(0));
        // add x3,x1,x2 with zero-wait memory
        v("add_f",  0, OP_R,  3'd0, 0, 0, 1, e_fetch(1));
        v("add_d",  0, OP_R,  3'd0, 0, 0, 0, e_dec());
        v("add_x",  0, OP_R,  3'd0, 0, 0, 0, e_exr(A_ADD));
        v("add_wb", 0, OP_R,  3'd0, 0, 0, 0, e_aluwb());
        v("sub_f",  0, OP_R,  3'd0, 1, 0, 1, e_fetch(1));
        v("sub_d",  0, OP_R,  3'd0, 1, 0, 0, e_dec());
        v("sub_x",  0, OP_R,  3'd0, 1, 0, 0, e_exr(A_SUB));
        v("sub_wb", 0, OP_R,  3'd0, 1, 0, 0, e_aluwb());
        // lw with one fetch wait and a 3-cycle read stall
        v("lw_fw",  0, OP_LD, 3'd2, 0, 0, 0, e_fetch(0));
        v("lw_f",   0, OP_LD, 3'd2, 0, 0, 1, e_fetch(1));
        v("lw_d",   0, OP_LD, 3'd2, 0, 0, 0, e_dec());
        v("lw_a",   0, OP_LD, 3'd2, 0, 0, 0, e_madr(2'b00));
        v("lw_r0",  0, OP_LD, 3'd2, 0, 0, 0, e_mrd());
        v("lw_r1",  0, OP_LD, 3'd2, 0, 0, 0, e_mrd());
        v("lw_r2",  0, OP_LD, 3'd2, 0, 0, 0, e_mrd());
        v("lw_r3",  0, OP_LD, 3'd2, 0, 0, 1, e_mrd());
        v("lw_wb",  0, OP_LD, 3'd2, 0, 0, 0, e_mwb());
        // branches
        v("beq1_f", 0, OP_BR, 3'd0, 0, 1, 1, e_fetch(1));
        v("beq1_d", 0, OP_BR, 3'd0, 0, 1, 0, e_dec());
        v("beq1_b", 0, OP_BR, 3'd0, 0, 1, 0, e_br(1));
        v("beq0_f", 0, OP_BR, 3'd0, 0, 0, 1, e_fetch(1));
        v("beq0_d", 0, OP_BR, 3'd0, 0, 0, 0, e_dec());
        v("beq0_b", 0, OP_BR, 3'd0, 0, 0, 0, e_br(0));
        v("bne0_f", 0, OP_BR, 3'd1, 0, 0, 1, e_fetch(1));
        v("bne0_d", 0, OP_BR, 3'd1, 0, 0, 0, e_dec());
        v("bne0_b", 0, OP_BR, 3'd1, 0, 0, 0, e_br(1));
        v("bne1_f", 0, OP_BR, 3'd1, 0, 1, 1, e_fetch(1));
        v("bne1_d", 0, OP_BR, 3'd1, 0, 1, 0, e_dec());
        v("bne1_b", 0, OP_BR, 3'd1, 0, 1, 0, e_br(0));
        // sw with one write stall
        v("sw_f",   0, OP_ST, 3'd2, 0, 0, 1, e_fetch(1));
        v("sw_d",   0, OP_ST, 3'd2, 0, 0, 0, e_dec());
        v("sw_a",   0, OP_ST, 3'd2, 0, 0, 0, e_madr(2'b01));
        v("sw_w0",  0, OP_ST, 3'd2, 0, 0, 0, e_mwr());
        v("sw_w1",  0, OP_ST, 3'd2, 0, 0, 1, e_mwr());
        // I-type and remaining R-type ops; funct7_5 ignored for I-type
        v("xori_f", 0, OP_I,  3'd4, 0, 0, 1, e_fetch(1));
        v("xori_d", 0, OP_I,  3'd4, 0, 0, 0, e_dec());
        v("xori_x", 0, OP_I,  3'd4, 0, 0, 0, e_exi(A_XOR));
        v("xoriwb", 0, OP_I,  3'd4, 0, 0, 0, e_aluwb());
        v("addi_f", 0, OP_I,  3'd0, 1, 0, 1, e_fetch(1));
        v("addi_d", 0, OP_I,  3'd0, 1, 0, 0, e_dec());
        v("addi_x", 0, OP_I,  3'd0, 1, 0, 0, e_exi(A_ADD));
        v("addiwb", 0, OP_I,  3'd0, 1, 0, 0, e_aluwb());
        v("or_f",   0, OP_R,  3'd6, 0, 0, 1, e_fetch(1));
        v("or_d",   0, OP_R,  3'd6, 0, 0, 0, e_dec());
        v("or_x",   0, OP_R,  3'd6, 0, 0, 0, e_exr(A_OR));
        v("or_wb",  0, OP_R,  3'd6, 0, 0, 0, e_aluwb());
        v("and_f",  0, OP_R,  3'd7, 0, 0, 1, e_fetch(1));
        v("and_d",  0, OP_R,  3'd7, 0, 0, 0, e_dec());
        v("and_x",  0, OP_R,  3'd7, 0, 0, 0, e_exr(A_AND));
        v("and_wb", 0, OP_R,  3'd7, 0, 0, 0, e_aluwb());
        // jal
        v("jal_f",  0, OP_JAL, 3'd0, 0, 0, 1, e_fetch(1));
        v("jal_d",  0, OP_JAL, 3'd0, 0, 0, 0, e_dec());
        v("jal_1",  0, OP_JAL, 3'd0, 0, 0, 0, e_jal1());
        v("jal_2",  0, OP_JAL, 3'd0, 0, 0, 0, e_jal2());
        // reset in the middle of a stalled store: mem_write must drop at once
        v("swr_f",  0, OP_ST, 3'd2, 0, 0, 1, e_fetch(1));
        v("swr_d",  0, OP_ST, 3'd2, 0, 0, 0, e_dec());
        v("swr_a",  0, OP_ST, 3'd2, 0, 0, 0, e_madr(2'b01));
        v("swr_w",  0, OP_ST, 3'd2, 0, 0, 0, e_mwr());
        v("swr_rs", 1, OP_ST, 3'd2, 0, 0, 0, e_fetch(0));
        // lui is unsupported: illegal trap, sticky until reset
        v("lui_f",  0, OP_LUI, 3'd0, 0, 0, 1, e_fetch(1));
        v("lui_d",  0, OP_LUI, 3'd0, 0, 0, 0, e_dec());
        v("lui_t0", 0, OP_LUI, 3'd0, 0, 0, 0, e_trap(2'b01));
        v("lui_t1", 0, OP_R,   3'd0, 0, 1, 1, e_trap(2'b01));
        v("lui_rs", 1, OP_R,   3'd0, 0, 0, 0, e_fetch(0));
        // slli (funct3 001) traps from EXECI
        v("sll_f",  0, OP_I,  3'd1, 0, 0, 1, e_fetch(1));
        v("sll_d",  0, OP_I,  3'd1, 0, 0, 0, e_dec());
        v("sll_x",  0, OP_I,  3'd1, 0, 0, 0, e_exi(A_ADD));
        v("sll_t",  0, OP_I,  3'd1, 0, 0, 1, e_trap(2'b01));
        v("sll_rs", 1, OP_I,  3'd1, 0, 0, 0, e_fetch(0));
        // fetch never acknowledged: 4 stalled cycles then timeout trap
        v("to_f0",  0, OP_R,  3'd0, 0, 0, 0, e_fetch(0));
        v("to_f1",  0, OP_R,  3'd0, 0, 0, 0, e_fetch(0));
        v("to_f2",  0, OP_R,  3'd0, 0, 0, 0, e_fetch(0));
        v("to_f3",  0, OP_R,  3'd0, 0, 0, 0, e_fetch(0));
        v("to_t0",  0, OP_R,  3'd0, 0, 0, 0, e_trap(2'b10));
        v("to_t1",  0, OP_R,  3'd0, 0, 0, 1, e_trap(2'b10));
        v("to_rs",  1, OP_R,  3'd0, 0, 0, 0, e_fetch(0));
        v("rec_f",  0, OP_R,  3'd0, 0, 0, 1, e_fetch(1));
        v("rec_d",  0, OP_R,  3'd0, 0, 0, 0, e_dec());

        foreach (vecs[i]) run_vec(i, vecs[i]);

`ifdef PERF_CNT_EN
        step(1, OP_R, 3'd0, 0, 0, 0);
        check32("ir_rst", instret, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(0, OP_R, 3'd0, 0, 0, 1);
            step(0, OP_R, 3'd0, 0, 0, 0);
            step(0, OP_R, 3'd0, 0, 0, 0);
            step(0, OP_R, 3'd0, 0, 0, 0);
        end
        step(0, OP_ST, 3'd2, 0, 0, 1);
        step(0, OP_ST, 3'd2, 0, 0, 0);
        step(0, OP_ST, 3'd2, 0, 0, 0);
        step(0, OP_ST, 3'd2, 0, 0, 1);
        step(0, OP_LUI, 3'd0, 0, 0, 1);
        check32("ir_four", instret, 32'd4);
        step(0, OP_LUI, 3'd0, 0, 0, 0);
        step(0, OP_LUI, 3'd0, 0, 0, 0);
        step(0, OP_LUI, 3'd0, 0, 0, 1);
        check32("ir_trap", instret, 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
